fe_frame_tx: RTL and testbench

FE_FRAME_TX -- requirements
Module: fe_frame_tx

---
 rtl/fe_frame_tx_pkg.sv | 20 ++
 rtl/fe_frame_tx.sv | 129 ++++++++++++
 tb/tb_fe_frame_tx.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fe_frame_tx_pkg.sv
// Shared types and widths for the frame transmitter.
// Header is cmd, len MSB, len LSB; payload follows.
package fe_frame_tx_pkg;

  localparam int BYTE_W  = 8;
  localparam int LEN_W   = 16;
  localparam int HDR_LEN = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_CMD,
    S_HDR_LH,
    S_HDR_LL,
    S_RD_REQ,
    S_RD_WAIT,
    S_DATA,
    S_FIN
  } state_e;

endpackage

// File: rtl/fe_frame_tx.sv
// Frame transmitter: sends cmd, 16-bit len (MSB first), then payload
// pulled one byte at a time from an external FIFO into a UART.
module fe_frame_tx
  import fe_frame_tx_pkg::*;
#(
  parameter logic [LEN_W-1:0] TIMEOUT = 16'd65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] cmd_in,
  input  logic [LEN_W-1:0]  len_in,
  input  logic              fifo_empty,
  input  logic [BYTE_W-1:0] fifo_rdata,
  output logic              fifo_rd,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e             state_q, state_d;
  logic [BYTE_W-1:0]  cmd_q, cmd_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [LEN_W-1:0]   tmo_q, tmo_d;
  logic [BYTE_W-1:0]  data_q, data_d;
  logic               err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    len_d    = len_q;
    rem_d    = rem_q;
    tmo_d    = tmo_q;
    data_d   = data_q;
    err_d    = err_q;
    fifo_rd  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cmd_d   = cmd_in;
          len_d   = len_in;
          rem_d   = len_in;
          tmo_d   = '0;
          err_d   = 1'b0;
          state_d = S_HDR_CMD;
        end
      end
      S_HDR_CMD: begin
        tx_valid = 1'b1;
        tx_data  = cmd_q;
        if (tx_ready) state_d = S_HDR_LH;
      end
      S_HDR_LH: begin
        tx_valid = 1'b1;
        tx_data  = len_q[LEN_W-1:BYTE_W];
        if (tx_ready) state_d = S_HDR_LL;
      end
      S_HDR_LL: begin
        tx_valid = 1'b1;
        tx_data  = len_q[BYTE_W-1:0];
        if (tx_ready) begin
          state_d = (len_q == '0) ? S_FIN : S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          tmo_d   = '0;
          state_d = S_RD_WAIT;
        end else begin
          // abort once the wait has lasted TIMEOUT cycles
          tmo_d = tmo_q + 1'b1;
          if (tmo_d == TIMEOUT) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end
        end
      end
      S_RD_WAIT: begin
        data_d  = fifo_rdata;
        state_d = S_DATA;
      end
      S_DATA: begin
        tx_valid = 1'b1;
        tx_data  = data_q;
        if (tx_ready) begin
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == 16'd1) ? S_FIN : S_RD_REQ;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign err  = err_q;

endmodule

// File: tb/tb_fe_frame_tx.sv
// Scoreboard bench for fe_frame_tx: randomized frames, stalls,
// timeout abort, mid-frame reset and ignored start pulses.
module tb_fe_frame_tx;

  localparam logic [15:0] TMO = 16'd8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  cmd_in;
  logic [15:0] len_in;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata;
  logic        fifo_rd;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;
  logic        err;

  fe_frame_tx #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cmd_in    (cmd_in),
    .len_in    (len_in),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_rd   (fifo_rd),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];
  logic       exp_err_q[$];
  logic [7:0] fifo_q[$];
  logic [7:0] pay_q[$];

  bit  stall_en = 1'b0;
  bit  rdy_rand = 1'b0;
  bit  rd_s;
  int  run;
  int  cyc = 0;
  int  last_xfer = 0;
  int  frames = 0;
  int  xfers = 0;
  int  rd_cnt = 0;
  bit  pv = 1'b0;
  logic [7:0] pd;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // External FIFO and UART-ready model, driven just after each edge
  always begin
    @(negedge clk);
    rd_s = fifo_rd;
    @(posedge clk);
    #1;
    if (rd_s && fifo_q.size() > 0) fifo_rdata = fifo_q.pop_front();
    if (stall_en && run < 3 && $urandom_range(0, 2) == 0) begin
      fifo_empty = 1'b1;
      run++;
    end else begin
      fifo_empty = (fifo_q.size() == 0);
      run = 0;
    end
    tx_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitor: pops expected bytes / frame results as the DUT presents them
  always @(negedge clk) begin
    logic e;
    cyc++;
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (fifo_rd) begin
        rd_cnt++;
        check("rd_while_empty", {31'd0, fifo_empty}, 32'd0);
      end
      if (pv) begin
        check("stall_valid", {31'd0, tx_valid}, 32'd1);
        check("stall_data", {24'd0, tx_data}, {24'd0, pd});
      end
      if (tx_valid && tx_ready) begin
        xfers++;
        last_xfer = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_byte: got %0h expected none", tx_data);
        end else begin
          check("byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        end
      end
      if (done) begin
        frames++;
        if (exp_err_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_done: got done expected none");
        end else begin
          e = exp_err_q.pop_front();
          check("err", {31'd0, err}, {31'd0, e});
          check("done_gap", cyc - last_xfer, e ? 32'd9 : 32'd1);
          check("busy_at_done", {31'd0, busy}, 32'd1);
        end
      end
      pv = tx_valid && !tx_ready;
      pd = tx_data;
    end
  end

  // Reference model: header, then min(len, available) payload bytes;
  // fewer bytes than len means a timeout abort.
  task automatic send(input logic [7:0] c, input logic [15:0] l);
    int avail;
    avail = pay_q.size();
    exp_q.push_back(c);
    exp_q.push_back(l[15:8]);
    exp_q.push_back(l[7:0]);
    for (int i = 0; i < avail; i++) begin
      fifo_q.push_back(pay_q[i]);
      if (i < int'(l)) exp_q.push_back(pay_q[i]);
    end
    exp_err_q.push_back(avail < int'(l));
    pay_q.delete();
    @(negedge clk);
    for (int i = 0; i < 5000 && busy; i++) @(negedge clk);
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_wait: got busy expected idle");
    end
    start  = 1'b1;
    cmd_in = c;
    len_in = l;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_frame(input int f0);
    for (int i = 0; i < 3000 && frames == f0; i++) @(posedge clk);
    if (frames == f0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL frame_timeout: got no done expected done");
    end
    @(negedge clk);
  endtask

  initial begin
    int f0;
    int r0;
    int x0;
    rst    = 1'b1;
    start  = 1'b0;
    cmd_in = '0;
    len_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rd", {31'd0, fifo_rd}, 32'd0);
    check("rst_data", {24'd0, tx_data}, 32'd0);

    // Basic frame with two payload bytes
    pay_q = '{8'h11, 8'h22};
    f0 = frames;
    r0 = rd_cnt;
    send(8'hA5, 16'd2);
    wait_frame(f0);
    check("basic_reads", rd_cnt - r0, 32'd2);

    // Empty payload: header only, no FIFO reads
    f0 = frames;
    r0 = rd_cnt;
    send(8'h3C, 16'd0);
    wait_frame(f0);
    check("len0_reads", rd_cnt - r0, 32'd0);

    // Random back-pressure on a 4-byte frame
    rdy_rand = 1'b1;
    pay_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    f0 = frames;
    x0 = xfers;
    send(8'h42, 16'd4);
    wait_frame(f0);
    check("stall_xfers", xfers - x0, 32'd7);

    // Randomized frames with FIFO and UART stalls
    stall_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      int l;
      l = $urandom_range(0, 6);
      for (int i = 0; i < l; i++) pay_q.push_back(8'($urandom));
      f0 = frames;
      send(8'($urandom), 16'(l));
      wait_frame(f0);
    end
    stall_en = 1'b0;
    rdy_rand = 1'b0;

    // Timeout: one byte available out of three
    pay_q = '{8'h5E};
    f0 = frames;
    send(8'h77, 16'd3);
    wait_frame(f0);

    // Maximum length, aborted by timeout after two bytes
    pay_q = '{8'hD0, 8'hD1};
    f0 = frames;
    send(8'h99, 16'hFFFF);
    wait_frame(f0);

    // Reset while payload byte 2 is presented
    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    x0 = xfers;
    f0 = frames;
    send(8'h5A, 16'd4);
    for (int i = 0; i < 200 && !(xfers - x0 == 4 && tx_valid); i++)
      @(negedge clk);
    check("rst_point", xfers - x0, 32'd4);
    #2 rst = 1'b1;
    #1;
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_valid", {31'd0, tx_valid}, 32'd0);
    check("mid_data", {24'd0, tx_data}, 32'd0);
    check("mid_done", {31'd0, done}, 32'd0);
    check("mid_err", {31'd0, err}, 32'd0);
    check("mid_rd", {31'd0, fifo_rd}, 32'd0);
    exp_q.delete();
    exp_err_q.delete();
    fifo_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("no_done_after_rst", frames - f0, 32'd0);
    pay_q = '{8'hE1, 8'hE2, 8'hE3};
    f0 = frames;
    send(8'hB7, 16'd3);
    wait_frame(f0);

    // Start while busy and start in the done cycle are both ignored
    pay_q = '{8'h31, 8'h32, 8'h33};
    f0 = frames;
    send(8'h6D, 16'd3);
    repeat (3) @(negedge clk);
    start  = 1'b1;
    cmd_in = 8'hEE;
    len_in = 16'd5;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    check("done_seen", {31'd0, done}, 32'd1);
    start  = 1'b1;
    cmd_in = 8'hEF;
    len_in = 16'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("one_frame", frames - f0, 32'd1);
    check("idle_after", {31'd0, busy}, 32'd0);

    check("left_bytes", exp_q.size(), 32'd0);
    check("left_done", exp_err_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1, "watchdog");
  end

endmodule
